mainfsm: RTL
============

# mainfsm

Multicycle sequencing controller for the ARM-subset core: a Moore state machine that walks each instruction through fetch, decode, execute, memory and writeback. It replaces the single-cycle control path by issuing per-cycle enables and mux selects to the shared datapath, with one ALU and one unified instruction/data memory. Inputs are the instruction's Op/Funct fields and a memory-ready handshake. Outputs feed the datapath muxes directly, and feed `condlogic`, which gates RegW/MemW/NextPC with the condition check.

## Interface
Parameters: none.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset; low forces state FETCH immediately.
- `Op` input 2: instruction bits [27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal.
- `Funct` input 6: instruction bits [25:20]; [5] is the I (immediate) flag, [0] is the L/S flag.
- `MemReady` input 1: memory completes the current access this cycle.
- `IRWrite` output 1: load instruction register.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALU result register.
- `ALUSrcA` output 1: ALU A select; 0 = register A, 1 = PC.
- `ALUSrcB` output 2: ALU B select; 00 = register B, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` output 2: result bus select; 00 = ALUOut, 01 = Data, 10 = ALU direct.
- `ALUOp` output 1: 1 lets `decode` derive ALUControl/FlagW from Funct; 0 forces ADD with no flag write.
- `NextPC` output 1: PC write request.
- `RegW` output 1: register write request.
- `MemW` output 1: memory write request.
- `Branch` output 1: branch PC write request.
- `Illegal` output 1: undefined opcode seen; pulses for one cycle.

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN. The encoding is implementer's choice; the state is 4 bits wide.

Unlisted outputs are 0 in every state.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=MemReady and NextPC=MemReady.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. This reads registers and computes PC+8.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. MemW is held high until the access completes.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- UNKNOWN: Illegal=1.

Transitions:
- FETCH→DECODE when MemReady=1, else stay in FETCH.
- DECODE branches on Op:
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=1 → EXECUTEI.
  - Op=00 with Funct[5]=0 → EXECUTER.
  - Op=10 → BRANCH.
  - Op=11 → UNKNOWN.
- MEMADR→MEMRD if Funct[0]=1, else MEMWR.
- MEMRD→MEMWB when MemReady=1, else stay.
- MEMWR→FETCH when MemReady=1, else stay.
- MEMWB, ALUWB, BRANCH and UNKNOWN → FETCH unconditionally.
- EXECUTER and EXECUTEI → ALUWB.

Rules:
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Op/Funct are sampled from the instruction register and must be stable from DECODE until the return to FETCH. The FSM does not latch them.
- Condition failure is not handled here: `condlogic` suppresses the writes, and the sequence still completes.

## Timing
- Reset asserted (async, low): state is FETCH immediately. Outputs take FETCH values, with IRWrite and NextPC following MemReady.
- Reset released: the first transition happens on the first rising edge with reset high.
- Reset asserted mid-instruction aborts it immediately. No further RegW or MemW is issued; any write already strobed stays committed.
- Outputs are combinational from state, plus the MemReady gating in FETCH. There are no registered-output delays.
- Latency in cycles with MemReady held at 1:
  - LDR: 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB).
  - STR: 4.
  - Data-processing (register or immediate): 4.
  - Branch: 3.
  - Illegal: 3.
- Each cycle MemReady is low in a wait state adds exactly one cycle.
- No double strobe while stalled:
  - IRWrite and NextPC are asserted only on the single completing FETCH cycle.
  - RegW is asserted for exactly one cycle per instruction.
  - MemW stays high for the entire MEMWR stall.

## Test plan
- Reset then ADD register: reset low 2 cycles, release, Op=00, Funct=001000, MemReady=1 → states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=1 only in EXECUTER, RegW=1 only in ALUWB, IRWrite=1 only in cycle 0.
- LDR with memory stall: Op=01, Funct=011001, MemReady low for 2 cycles in MEMRD → MEMRD held 3 cycles, then MEMWB with ResultSrc=01 and RegW=1 for exactly one cycle. Total 7 cycles.
- STR with fetch stall: MemReady=0 for 3 cycles in FETCH, then 1; Op=01, Funct=011000 → IRWrite and NextPC high only in the 4th FETCH cycle. MEMWR has AdrSrc=1 and MemW=1, then FETCH.
- Immediate and branch: Op=00, Funct=101001 → EXECUTEI with ALUSrcB=01. Op=10 → BRANCH with Branch=1 and ALUSrcB=01, then FETCH. Total 3 cycles.
- Illegal opcode: Op=11 → UNKNOWN with Illegal=1 for one cycle, RegW=MemW=NextPC=0 throughout after FETCH, then FETCH.
- Async reset mid-store: reset low during the 2nd cycle of a stalled MEMWR → MemW drops to 0 without waiting for an edge, state is FETCH, and a new fetch starts after release.

Source files
------------

// File: rtl/mainfsm.sv
// Multicycle sequencing controller: Moore FSM stepping each instruction through fetch/decode/execute/memory/writeback.
// Outputs are combinational from state; MemReady stalls FETCH, MEMRD and MEMWR and gates IRWrite/NextPC in FETCH.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] UNKNOWN  = 4'd10;

  logic [3:0] state;
  logic [3:0] state_nxt;

  // Only the I and L/S flags steer sequencing; the rest of Funct belongs to decode.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = UNKNOWN;
        endcase
      end
      MEMADR:   state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_nxt = MemReady ? MEMWB : MEMRD;
      MEMWR:    state_nxt = MemReady ? FETCH : MEMWR;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Illegal   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      UNKNOWN:  Illegal = 1'b1;
      default:  Illegal = 1'b0;
    endcase
  end

endmodule
